// File: rtl/ofm_axis_packer_if.sv
// AXI-Stream beat channel used by ofm_axis_packer toward the DMA S2MM port.
// The master drives the data, valid, last and keep signals; the slave drives ready.
interface ofm_axis_packer_if #(
  parameter int DW = 8
);
  logic [4*DW-1:0] tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;
  logic [3:0]      tkeep;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/ofm_axis_packer.sv
// ofm_axis_packer: drains the OFM byte buffer as 32-bit AXI-Stream beats, one frame per start.
// Define OFM_STALL_CNT_EN to get a saturating backpressure counter on stall_cnt.
module ofm_axis_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 2304,
  parameter int ADDR_W     = 12
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    buf_ce,
  output logic                    buf_we,
  output logic [ADDR_W-1:0]       buf_addr,
  input  logic [4*DATA_WIDTH-1:0] buf_q,
  ofm_axis_packer_if.master       m_axis,
  output logic [15:0]             stall_cnt
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | fetching words into the output FIFO
  // DRAIN | last word fetched, waiting for the FIFO to empty
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_DEPTH - 4);

  logic [1:0]              state;
  logic [ADDR_W-1:0]       rd_ptr;
  logic [1:0]              count;
  logic                    wr_idx;
  logic                    rd_idx;
  logic [4*DATA_WIDTH-1:0] fifo_data [2];
  logic                    fifo_last [2];
  logic                    fetch;
  logic                    fetch_last;
  logic                    pop;
  logic                    head_last;

  // Fetch depends only on registered count, never on tready.
  assign fetch      = (state == RUN) && (count < 2'd2);
  assign fetch_last = (rd_ptr == LAST_ADDR);
  assign pop        = m_axis.tvalid && m_axis.tready;
  assign head_last  = fifo_last[rd_idx];

  assign buf_ce   = fetch;
  assign buf_we   = 1'b0;
  assign buf_addr = fetch ? rd_ptr : '0;
  assign busy     = (state != IDLE);

  assign m_axis.tvalid = (count != 2'd0);
  assign m_axis.tdata  = fifo_data[rd_idx];
  assign m_axis.tlast  = m_axis.tvalid && head_last;
  assign m_axis.tkeep  = 4'hF;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      rd_ptr <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            rd_ptr <= '0;
          end
        end
        RUN: begin
          if (fetch) begin
            rd_ptr <= rd_ptr + ADDR_W'(4);
            if (fetch_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last-tagged entry is always the final one pushed, so its pop empties the FIFO.
          if (pop && head_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count        <= 2'd0;
      wr_idx       <= 1'b0;
      rd_idx       <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
    end else begin
      if (fetch) begin
        fifo_data[wr_idx] <= buf_q;
        fifo_last[wr_idx] <= fetch_last;
        wr_idx            <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      case ({fetch, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef OFM_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= 16'h0;
    end else if ((state == IDLE) && start) begin
      stall_q <= 16'h0;
    end else if (m_axis.tvalid && !m_axis.tready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_ofm_axis_packer.sv
// Directed bench for ofm_axis_packer: reset, latency, backpressure, restart and abort.
// Stall-count expectations follow OFM_STALL_CNT_EN.
module tb_ofm_axis_packer;
  logic        clk;
  logic        rstn;
  logic        start;
  logic        busy;
  logic        done;
  logic        buf_ce;
  logic        buf_we;
  logic [11:0] buf_addr;
  logic [31:0] buf_q;
  logic [15:0] stall_cnt;

  int ntests = 0;
  int nfail  = 0;
  int model_stall = 0;

  logic [7:0] mem [0:2303];

  ofm_axis_packer_if #(.DW(8)) axis ();

  ofm_axis_packer #(.DATA_WIDTH(8), .DATA_DEPTH(2304), .ADDR_W(12)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .buf_ce    (buf_ce),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_q     (buf_q),
    .m_axis    (axis),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    buf_q = '0;
    if (buf_addr <= 12'd2300)
      buf_q = {mem[buf_addr], mem[buf_addr + 12'd1], mem[buf_addr + 12'd2], mem[buf_addr + 12'd3]};
  end

  function automatic logic [31:0] exp_word(input int k);
    logic [7:0] b;
    b = 8'(k * 4);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_stall = 0;
  endtask

  // pat 0: always ready, 1: ready low for 10 cycles, 2: random ready plus stray starts.
  task automatic run_frame(input int pat, input int abort_beat);
    int k = 0;
    int cyc = 0;
    bit fin = 0;
    bit aborted = 0;
    bit stalled = 0;
    bit hs;
    logic [31:0] held = '0;
    while (!fin && cyc < 4000) begin
      case (pat)
        1:       axis.tready = !(cyc >= 50 && cyc < 60);
        2:       axis.tready = 1'($urandom_range(0, 1));
        default: axis.tready = 1'b1;
      endcase
      start = (pat == 2) && (cyc == 20 || cyc == 300);
      #1;
      if (abort_beat >= 0 && k == abort_beat) begin
        rstn = 1'b0;
        #1;
        check("abort_tvalid", axis.tvalid, 1'b0);
        check("abort_busy", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        rstn = 1'b1;
        fin = 1;
        aborted = 1;
      end else begin
        if (stalled) check("hold_tdata", axis.tdata, held);
        if (pat == 1 && cyc == 56) check("full_no_fetch", buf_ce, 1'b0);
        hs = axis.tvalid && axis.tready;
        if (hs) begin
          check("beat_data", axis.tdata, exp_word(k));
          check("beat_last", axis.tlast, (k == 575));
          k++;
        end
        if (axis.tvalid && !axis.tready) model_stall++;
        stalled = axis.tvalid && !axis.tready;
        held = axis.tdata;
        @(posedge clk); #1;
        cyc++;
        if (done || (hs && k == 576)) begin
          check("done_after_last", {done, busy}, {(hs && k == 576), 1'b0});
          check("beat_count", k, 576);
          fin = 1;
        end
      end
    end
    start = 1'b0;
    check("frame_completed", fin, 1'b1);
    if (fin && !aborted) begin
      @(posedge clk); #1;
      check("done_pulse_width", done, 1'b0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_buf_ce"}, buf_ce, 1'b0);
    check({tag, "_buf_we"}, buf_we, 1'b0);
    check({tag, "_buf_addr"}, buf_addr, 12'h0);
    check({tag, "_tvalid"}, axis.tvalid, 1'b0);
    check({tag, "_tlast"}, axis.tlast, 1'b0);
    check({tag, "_tkeep"}, axis.tkeep, 4'hF);
    check({tag, "_stall"}, stall_cnt, 16'h0);
  endtask

  task automatic check_stall(input string tag, input int exp_en);
`ifdef OFM_STALL_CNT_EN
    check(tag, stall_cnt, 16'(exp_en));
`else
    check(tag, stall_cnt, 16'h0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 2304; i++) mem[i] = 8'(i);
    rstn = 1'b0;
    start = 1'b0;
    axis.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rstn = 1'b1;
    axis.tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_tvalid_before_start", axis.tvalid, 1'b0);

    // Frame with tready held high, plus first-beat latency.
    start_frame();
    check("lat_busy", busy, 1'b1);
    check("lat_buf_ce", buf_ce, 1'b1);
    check("lat_buf_addr", buf_addr, 12'h0);
    check("lat_tvalid_n1", axis.tvalid, 1'b0);
    @(posedge clk); #1;
    check("lat_tvalid_n2", axis.tvalid, 1'b1);
    check("lat_beat0", axis.tdata, 32'h00010203);
    run_frame(0, -1);
    check_stall("stall_ready_frame", 0);

    // Ten cycles of backpressure mid-frame.
    start_frame();
    check_stall("stall_cleared_on_start", 0);
    run_frame(1, -1);
    check_stall("stall_ten_cycles", 10);
    repeat (4) @(posedge clk);
    #1;
    check_stall("stall_holds_after_done", 10);

    // Random backpressure with stray start pulses while busy.
    start_frame();
    run_frame(2, -1);
    check_stall("stall_random", model_stall);

    // Restart right after done.
    start_frame();
    run_frame(0, -1);

    // Reset at beat 100, then a fresh frame.
    start_frame();
    run_frame(0, 100);
    check_idle_outputs("after_abort");
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", axis.tvalid, 1'b0);
    start_frame();
    run_frame(0, -1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
